fourtwo_priority_encoder_sync: RTL and testbench

- Reverse direction of the team's 2-to-4 decoder. Takes four asynchronous one-hot-ish request lines, such as buttons or switches on the practice board.
- Synchronises and debounces the lines, then priority-encodes each press event into a 2-bit code.
- Presents the code to downstream logic with a valid/ack handshake.
- Feeds the decoder/display path in lab top levels.

---
 rtl/fourtwo_priority_encoder_sync.sv | 166 ++++++++++++++++
 tb/tb_fourtwo_priority_encoder_sync.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fourtwo_priority_encoder_sync.sv
// fourtwo_priority_encoder_sync
//   Synchronises, debounces and priority-encodes four raw request lines
//   (buttons/switches). Each 0000 -> nonzero press of the debounced vector
//   produces one report (code/multi) held with valid until ack.
//
// Ports
//   clk      system clock, all state on rising edge
//   rst      asynchronous active-high reset
//   din      raw request lines, din[3] highest priority
//   ack      downstream consumed the report (only honoured while valid=1)
//   code     index of highest set bit of the accepted press
//   valid    code/multi valid, held until ack
//   multi    more than one line was set in the accepted press
//   overrun  sticky; a press was dropped while a report was pending
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for debounced vector to go 0000 -> nonzero
// REPORT  | valid=1, code/multi held until ack
// RELEASE | report consumed, waiting for debounced vector to return to 0000
module fourtwo_priority_encoder_sync #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       ack,
   output logic [1:0] code,
   output logic       valid,
   output logic       multi,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REPORT  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   logic [3:0]       r_s1;
   logic [3:0]       r_s;
   logic [3:0]       r_s_prev;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_deb;
   logic [3:0]       r_deb_d;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_clr_valid;
   logic             w_set_ovr;

   logic             w_press;
   logic [1:0]       w_code;
   logic             w_multi;

   logic [1:0]       r_code;
   logic             r_valid;
   logic             r_multi;
   logic             r_overrun;

   // Synchroniser, debounce counter and debounced vector history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1     <= '0;
         r_s      <= '0;
         r_s_prev <= '0;
         r_cnt    <= '0;
         r_deb    <= '0;
         r_deb_d  <= '0;
      end else begin
         r_s1     <= din;
         r_s      <= r_s1;
         r_s_prev <= r_s;
         r_deb_d  <= r_deb;
         if (r_s != r_s_prev) begin
            r_cnt <= '0;
         end else begin
            if (r_cnt != CNT_MAX)
               r_cnt <= r_cnt + 1'b1;
            // Counter saturates above the load point, so deb loads only once per stable run
            if (r_cnt == CNT_LOAD)
               r_deb <= r_s;
         end
      end
   end

   // Press is seen one edge after deb rises; this sets the overall latency
   assign w_press = (r_deb_d == 4'b0000) && (r_deb != 4'b0000);

   always_comb begin
      w_code = 2'd0;
      if (r_deb[3])
         w_code = 2'd3;
      else if (r_deb[2])
         w_code = 2'd2;
      else if (r_deb[1])
         w_code = 2'd1;
   end

   assign w_multi = ($countones(r_deb) > 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_clr_valid = 1'b0;
      w_set_ovr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press) begin
               w_load      = 1'b1;
               w_state_nxt = REPORT;
            end
         end
         REPORT: begin
            if (ack) begin
               w_clr_valid = 1'b1;
               w_state_nxt = (r_deb == 4'b0000) ? IDLE : RELEASE;
            end else if (w_press) begin
               w_set_ovr = 1'b1;
            end
         end
         RELEASE: begin
            if (r_deb == 4'b0000)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_code    <= 2'd0;
         r_valid   <= 1'b0;
         r_multi   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_load) begin
            r_code  <= w_code;
            r_multi <= w_multi;
            r_valid <= 1'b1;
         end else if (w_clr_valid) begin
            r_valid <= 1'b0;
         end
         if (w_set_ovr)
            r_overrun <= 1'b1;
      end
   end

   assign code    = r_code;
   assign valid   = r_valid;
   assign multi   = r_multi;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_fourtwo_priority_encoder_sync.sv
module tb_fourtwo_priority_encoder_sync;

   localparam int D  = 4;
   localparam int HL = D + 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] din = 4'b0000;
   logic       ack = 1'b0;
   logic [1:0] code;
   logic       valid;
   logic       multi;
   logic       overrun;

   fourtwo_priority_encoder_sync #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .din     (din),
      .ack     (ack),
      .code    (code),
      .valid   (valid),
      .multi   (multi),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         edge_no;
      logic [1:0] code;
      logic       multi;
   } rep_t;

   rep_t       exp_q[$];
   int         n_vec  = 0;
   int         n_fail = 0;
   bit         done   = 0;

   // Reference model state
   logic [3:0] hist[HL];
   logic [3:0] m_deb   = 4'b0000;   // debounced vector after last edge
   logic [3:0] m_deb_p = 4'b0000;   // debounced vector one edge earlier
   bit         m_pend  = 0;
   bit         m_wrel  = 0;
   bit         m_ovr   = 0;
   logic [1:0] m_code  = 2'd0;
   logic       m_multi = 1'b0;
   int         cyc     = 0;

   function automatic logic [1:0] top_bit(input logic [3:0] v);
      for (int b = 3; b >= 0; b--)
         if (v[b]) return 2'(b);
      return 2'd0;
   endfunction

   function automatic int ones(input logic [3:0] v);
      int n = 0;
      for (int b = 0; b < 4; b++) n += int'(v[b]);
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < HL; i++) hist[i] = 4'b0000;
      m_deb = 0; m_deb_p = 0; m_pend = 0; m_wrel = 0; m_ovr = 0;
      m_code = 0; m_multi = 0;
      exp_q.delete();
   endtask

   // One rising edge of the model, using the din/ack applied before it.
   task automatic model_step();
      bit press;
      bit stable;
      cyc++;
      press = (m_deb_p == 0) && (m_deb != 0);
      if (m_pend) begin
         if (ack) begin
            m_pend = 0;
            m_wrel = (m_deb != 0);
         end else if (press) begin
            m_ovr = 1;
         end
      end else if (m_wrel) begin
         if (m_deb == 0) m_wrel = 0;
      end else if (press) begin
         rep_t r;
         m_pend  = 1;
         m_code  = top_bit(m_deb);
         m_multi = (ones(m_deb) >= 2);
         r.edge_no = cyc; r.code = m_code; r.multi = m_multi;
         exp_q.push_back(r);
      end
      // Two edges of synchroniser delay, then D+1 identical samples accept a value
      for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = din;
      stable = 1;
      for (int j = 3; j <= D + 2; j++)
         if (hist[j] != hist[2]) stable = 0;
      m_deb_p = m_deb;
      if (stable) m_deb = hist[2];
   endtask

   task automatic cycle(input logic [3:0] d, input logic a);
      @(negedge clk);
      din = d;
      ack = a;
      @(posedge clk);
      model_step();
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: per-cycle output check plus scoreboard pop on each new report
   initial begin : monitor
      logic prev_v;
      rep_t r;
      prev_v = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (done) break;
         chk("valid", int'(valid), int'(m_pend));
         chk("overrun", int'(overrun), int'(m_ovr));
         chk("code_held", int'(code), int'(m_code));
         chk("multi_held", int'(multi), int'(m_multi));
         if (valid && !prev_v) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_report", 1, 0);
            end else begin
               r = exp_q.pop_front();
               chk("report_edge", cyc, r.edge_no);
               chk("report_code", int'(code), int'(r.code));
               chk("report_multi", int'(multi), int'(r.multi));
            end
         end
         prev_v = valid;
      end
   end

   initial begin : stim
      logic [3:0] pat;
      int         len;
      bit         got;
      model_reset();
      #1;
      chk("rst_valid", int'(valid), 0);
      chk("rst_code", int'(code), 0);
      chk("rst_multi", int'(multi), 0);
      chk("rst_overrun", int'(overrun), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed: single press 0100 with ack after the report
      for (int i = 0; i < 12; i++) cycle(4'b0100, 1'b0);
      cycle(4'b0100, 1'b1);
      for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
      // Directed: glitches of 1..3 cycles never report
      for (int g = 1; g <= 3; g++) begin
         for (int i = 0; i < g; i++) cycle(4'b0010, 1'b0);
         for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
      end
      // Directed: 1011 then 0001 without release, then overrun sequence
      for (int i = 0; i < 10; i++) cycle(4'b1011, 1'b0);
      for (int i = 0; i < 10; i++) cycle(4'b0001, 1'b0);
      for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);
      for (int i = 0; i < 10; i++) cycle(4'b0010, 1'b0);
      cycle(4'b0010, 1'b1);
      for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b0);

      for (int seg = 0; seg < 500; seg++) begin
         if (seg == 250) begin
            // Async reset while a report is pending
            for (int i = 0; i < 12; i++) cycle(4'b0000, 1'b1);
            got = 0;
            for (int i = 0; i < 30 && !got; i++) begin
               cycle(4'b0100, 1'b0);
               got = m_pend;
            end
            chk("reset_setup_timeout", int'(got), 1);
            #2;
            rst = 1'b1;
            model_reset();
            #1;
            chk("async_valid", int'(valid), 0);
            chk("async_code", int'(code), 0);
            chk("async_multi", int'(multi), 0);
            chk("async_overrun", int'(overrun), 0);
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            din = 4'b0000;
            ack = 1'b0;
            rst = 1'b0;
            for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b0);
         end
         pat = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         len = int'($urandom_range(1, 12));
         for (int i = 0; i < len; i++)
            cycle(pat, m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0));
      end
      for (int i = 0; i < 12; i++) cycle(4'b0000, 1'b1);
      @(negedge clk);
      chk("leftover_reports", exp_q.size(), 0);
      done = 1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
